// File: rtl/score_arbiter.sv
// Round-robin arbiter that funnels N requesters onto one inc/dec/erase command path.
// Erase requests win over inc/dec, and every issued command is followed by GAP idle cycles.
module score_arbiter #(
    parameter int N   = 4,
    parameter int GAP = 1,
    parameter int IW  = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [2*N-1:0] op,
    output logic [N-1:0]   ack,
    output logic           inc_o,
    output logic           dec_o,
    output logic           erase_o,
    output logic [IW-1:0]  grant_id,
    output logic           busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam int            CW       = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [IW:0]   N_W      = (IW+1)'(N);
    localparam logic [IW-1:0] LAST     = IW'(N - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP - 1);

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] gap_cnt_q, gap_cnt_d;
    logic [IW-1:0] grant_id_q, grant_id_d;
    logic [N-1:0]  ack_q, ack_d;
    logic          inc_q, inc_d;
    logic          dec_q, dec_d;
    logic          erase_q, erase_d;
    logic          busy_q, busy_d;

    logic [N-1:0]  valid;
    logic [N-1:0]  is_erase;
    logic [N-1:0]  cand;
    logic          found;
    logic [IW-1:0] win;
    logic [IW:0]   sum;
    logic [1:0]    win_op;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_req
            assign valid[gi]    = req[gi] & (op[2*gi +: 2] != 2'b00);
            assign is_erase[gi] = req[gi] & (op[2*gi +: 2] == 2'b11);
        end
    endgenerate

    // Any pending erase masks out every inc/dec requester for this round.
    assign cand = (|is_erase) ? is_erase : valid;

    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr_q} + (IW+1)'(k);
            if (sum >= N_W) begin
                sum = sum - N_W;
            end
            if (!found && cand[sum[IW-1:0]]) begin
                found = 1'b1;
                win   = sum[IW-1:0];
            end
        end
    end

    assign win_op = op[{win, 1'b0} +: 2];

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gap_cnt_d  = gap_cnt_q;
        grant_id_d = grant_id_q;
        ack_d      = '0;
        inc_d      = 1'b0;
        dec_d      = 1'b0;
        erase_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Command outputs are loaded here so they are visible during ISSUE.
                if (found) begin
                    state_d      = S_ISSUE;
                    grant_id_d   = win;
                    ack_d[win]   = 1'b1;
                    inc_d        = (win_op == 2'b01);
                    dec_d        = (win_op == 2'b10);
                    erase_d      = (win_op == 2'b11);
                end
            end
            S_ISSUE: begin
                ptr_d     = (grant_id_q == LAST) ? '0 : grant_id_q + IW'(1);
                gap_cnt_d = GAP_LOAD;
                state_d   = S_GAP;
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            gap_cnt_q  <= '0;
            grant_id_q <= '0;
            ack_q      <= '0;
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            erase_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gap_cnt_q  <= gap_cnt_d;
            grant_id_q <= grant_id_d;
            ack_q      <= ack_d;
            inc_q      <= inc_d;
            dec_q      <= dec_d;
            erase_q    <= erase_d;
            busy_q     <= busy_d;
        end
    end

    assign ack      = ack_q;
    assign inc_o    = inc_q;
    assign dec_o    = dec_q;
    assign erase_o  = erase_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_score_arbiter.sv
// Scoreboard bench for score_arbiter: a default N=4/GAP=1 instance and an N=3/GAP=3 instance.
module tb_score_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    localparam logic [2:0] C_INC = 3'b001;
    localparam logic [2:0] C_DEC = 3'b010;
    localparam logic [2:0] C_ERA = 3'b100;

    typedef struct {
        int         id;
        logic [2:0] cmd;
    } exp_t;
    exp_t exp_q[$];

    logic       rst;
    logic [3:0] req;
    logic [7:0] op;
    logic [3:0] ack;
    logic       inc_o, dec_o, erase_o;
    logic [1:0] grant_id;
    logic       busy;

    logic       rst2;
    logic [2:0] req2;
    logic [5:0] op2;
    logic [2:0] ack2;
    logic       inc2, dec2, erase2;
    logic [1:0] gid2;
    logic       busy2;

    score_arbiter u_dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .ack(ack),
        .inc_o(inc_o), .dec_o(dec_o), .erase_o(erase_o),
        .grant_id(grant_id), .busy(busy)
    );

    score_arbiter #(.N(3), .GAP(3)) u_dut2 (
        .clk(clk), .rst(rst2), .req(req2), .op(op2), .ack(ack2),
        .inc_o(inc2), .dec_o(dec2), .erase_o(erase2),
        .grant_id(gid2), .busy(busy2)
    );

    int pulse_cnt = 0;
    int busy_cnt  = 0;
    int multi_cnt = 0;
    always @(negedge clk) begin
        if ({erase_o, dec_o, inc_o} != 3'b000) pulse_cnt++;
        if (busy) busy_cnt++;
        if ($countones({erase_o, dec_o, inc_o}) > 1) multi_cnt++;
        if ($countones({erase2, dec2, inc2}) > 1) multi_cnt++;
    end

    // Waits (bounded) for the next command or ack cycle of the selected instance.
    task automatic get_pulse(input bit which, input int limit, output bit got,
                             output logic [2:0] cmd, output logic [3:0] ackv,
                             output logic [1:0] gid, output int at);
        got = 1'b0; cmd = '0; ackv = '0; gid = '0; at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (which == 1'b0) begin
                cmd = {erase_o, dec_o, inc_o}; ackv = ack; gid = grant_id;
            end else begin
                cmd = {erase2, dec2, inc2}; ackv = {1'b0, ack2}; gid = gid2;
            end
            if (cmd != 3'b000 || ackv != 4'b0000) begin
                got = 1'b1;
                at  = cyc;
                break;
            end
        end
    endtask

    task automatic do_reset1();
        rst = 1'b1; req = '0; op = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bit got; logic [2:0] cmd; logic [3:0] ackv; logic [1:0] gid; int at; int rel; exp_t e;
        rst = 1'b1; req = 4'hF; op = 8'h55;
        exp_q.push_back('{id: 0, cmd: C_INC});
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rel = cyc;
        @(negedge clk);
        total++; if (ack !== 4'b0000) begin bad++; $display("FAIL reset_ack: got %b want 0000", ack); end
        total++; if ({erase_o, dec_o, inc_o} !== 3'b000) begin bad++; $display("FAIL reset_cmd: got %b want 000", {erase_o, dec_o, inc_o}); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_gid: got %0d want 0", grant_id); end
        get_pulse(1'b0, 10, got, cmd, ackv, gid, at);
        e = exp_q.pop_front();
        total++; if (!got || at != rel + 1) begin bad++; $display("FAIL reset_first_cycle: got cycle %0d want %0d", at, rel + 1); end
        total++; if (cmd !== e.cmd) begin bad++; $display("FAIL reset_first_cmd: got %b want %b", cmd, e.cmd); end
        total++; if (ackv !== (4'b0001 << e.id) || gid !== 2'(e.id)) begin bad++; $display("FAIL reset_first_grant: got ack %b id %0d want id %0d", ackv, gid, e.id); end
        @(posedge clk); #1 req = '0;
        $display("test_reset: first grant id=%0d at cycle %0d", gid, at);
    endtask

    task automatic test_single();
        bit got; logic [2:0] cmd; logic [3:0] ackv; logic [1:0] gid; int at; int t; int p0; exp_t e;
        @(posedge clk); #1;
        req = 4'b0010; op = 8'h04;
        t = cyc; p0 = pulse_cnt;
        exp_q.push_back('{id: 1, cmd: C_INC});
        get_pulse(1'b0, 10, got, cmd, ackv, gid, at);
        e = exp_q.pop_front();
        total++; if (!got || at != t + 1) begin bad++; $display("FAIL single_cycle: got cycle %0d want %0d", at, t + 1); end
        total++; if (cmd !== e.cmd) begin bad++; $display("FAIL single_cmd: got %b want %b", cmd, e.cmd); end
        total++; if (ackv !== 4'b0010) begin bad++; $display("FAIL single_ack: got %b want 0010", ackv); end
        total++; if (gid !== 2'(e.id)) begin bad++; $display("FAIL single_gid: got %0d want %0d", gid, e.id); end
        @(posedge clk); #1 req = '0;
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_gap: got %b want 1", busy); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_idle: got %b want 0", busy); end
        repeat (5) @(negedge clk);
        total++; if (pulse_cnt - p0 != 1) begin bad++; $display("FAIL single_pulse_count: got %0d want 1", pulse_cnt - p0); end
        $display("test_single: id=%0d cmd=%b at cycle %0d", gid, cmd, at);
    endtask

    task automatic test_round_robin();
        bit got; logic [2:0] cmd; logic [3:0] ackv; logic [1:0] gid; int at; int rel; exp_t e;
        int order[5] = '{0, 2, 3, 0, 2};
        do_reset1();
        req = 4'b1101; op = 8'hAA;
        rel = cyc;
        foreach (order[k]) exp_q.push_back('{id: order[k], cmd: C_DEC});
        for (int k = 0; k < 5; k++) begin
            get_pulse(1'b0, 12, got, cmd, ackv, gid, at);
            e = exp_q.pop_front();
            total++; if (!got || at != rel + 1 + 3 * k) begin bad++; $display("FAIL rr_cycle[%0d]: got cycle %0d want %0d", k, at, rel + 1 + 3 * k); end
            total++; if (cmd !== e.cmd) begin bad++; $display("FAIL rr_cmd[%0d]: got %b want %b", k, cmd, e.cmd); end
            total++; if (gid !== 2'(e.id) || ackv !== (4'b0001 << e.id)) begin bad++; $display("FAIL rr_grant[%0d]: got id %0d ack %b want id %0d", k, gid, ackv, e.id); end
            $display("test_round_robin: grant %0d id=%0d at cycle %0d", k, gid, at);
        end
        @(posedge clk); #1 req = '0;
    endtask

    task automatic test_erase_priority();
        bit got; logic [2:0] cmd; logic [3:0] ackv; logic [1:0] gid; int at; int rel; exp_t e;
        do_reset1();
        req = 4'b1011; op = 8'b01_00_11_01;
        rel = cyc;
        exp_q.push_back('{id: 1, cmd: C_ERA});
        exp_q.push_back('{id: 3, cmd: C_INC});
        exp_q.push_back('{id: 0, cmd: C_INC});
        for (int k = 0; k < 3; k++) begin
            get_pulse(1'b0, 12, got, cmd, ackv, gid, at);
            e = exp_q.pop_front();
            total++; if (!got || at != rel + 1 + 3 * k) begin bad++; $display("FAIL erase_cycle[%0d]: got cycle %0d want %0d", k, at, rel + 1 + 3 * k); end
            total++; if (cmd !== e.cmd) begin bad++; $display("FAIL erase_cmd[%0d]: got %b want %b", k, cmd, e.cmd); end
            total++; if (gid !== 2'(e.id) || ackv !== (4'b0001 << e.id)) begin bad++; $display("FAIL erase_grant[%0d]: got id %0d ack %b want id %0d", k, gid, ackv, e.id); end
            $display("test_erase_priority: grant %0d id=%0d cmd=%b at cycle %0d", k, gid, cmd, at);
            @(posedge clk); #1 req[e.id] = 1'b0;
        end
        req = '0; op = '0;
    endtask

    task automatic test_null_and_opchange();
        bit got; logic [2:0] cmd; logic [3:0] ackv; logic [1:0] gid; int at; int t; int p0; int b0; exp_t e;
        @(posedge clk); #1;
        req = 4'b0100; op = 8'h00;
        p0 = pulse_cnt; b0 = busy_cnt;
        repeat (6) @(negedge clk);
        total++; if (pulse_cnt != p0) begin bad++; $display("FAIL null_pulses: got %0d want 0", pulse_cnt - p0); end
        total++; if (busy_cnt != b0) begin bad++; $display("FAIL null_busy: got %0d busy cycles want 0", busy_cnt - b0); end
        @(posedge clk); #1 op = 8'b00_01_00_00;
        t = cyc;
        exp_q.push_back('{id: 2, cmd: C_INC});
        @(posedge clk); #1 op = 8'b00_10_00_00;
        get_pulse(1'b0, 10, got, cmd, ackv, gid, at);
        e = exp_q.pop_front();
        total++; if (!got || at != t + 1) begin bad++; $display("FAIL opchg_cycle: got cycle %0d want %0d", at, t + 1); end
        total++; if (cmd !== e.cmd) begin bad++; $display("FAIL opchg_cmd: got %b want %b", cmd, e.cmd); end
        total++; if (gid !== 2'(e.id) || ackv !== 4'b0100) begin bad++; $display("FAIL opchg_grant: got id %0d ack %b want id 2", gid, ackv); end
        @(posedge clk); #1 req = '0; op = '0;
        repeat (5) @(negedge clk);
        total++; if (pulse_cnt - p0 != 1) begin bad++; $display("FAIL opchg_pulse_count: got %0d want 1", pulse_cnt - p0); end
        $display("test_null_and_opchange: id=%0d cmd=%b at cycle %0d", gid, cmd, at);
    endtask

    task automatic test_reset_mid_gap3();
        bit got; logic [2:0] cmd; logic [3:0] ackv; logic [1:0] gid; int at; int rel; exp_t e;
        int post[4] = '{0, 1, 2, 0};
        rst2 = 1'b1; req2 = '0; op2 = '0;
        @(posedge clk); #1;
        rst2 = 1'b0; req2 = 3'b110; op2 = 6'h15;
        rel = cyc;
        exp_q.push_back('{id: 1, cmd: C_INC});
        exp_q.push_back('{id: 2, cmd: C_INC});
        for (int k = 0; k < 2; k++) begin
            get_pulse(1'b1, 12, got, cmd, ackv, gid, at);
            e = exp_q.pop_front();
            total++; if (!got || at != rel + 1 + 5 * k) begin bad++; $display("FAIL g3_pre_cycle[%0d]: got cycle %0d want %0d", k, at, rel + 1 + 5 * k); end
            total++; if (cmd !== e.cmd || gid !== 2'(e.id) || ackv !== (4'b0001 << e.id)) begin bad++; $display("FAIL g3_pre_grant[%0d]: got id %0d cmd %b ack %b want id %0d", k, gid, cmd, ackv, e.id); end
            $display("test_reset_mid_gap3: pre grant id=%0d at cycle %0d", gid, at);
        end
        // Still in the ISSUE cycle of the second grant: reset lands on the edge that ends it.
        rst2 = 1'b1; req2 = 3'b111;
        @(posedge clk); #1 rst2 = 1'b0;
        rel = cyc;
        @(negedge clk);
        total++; if ({ack2, erase2, dec2, inc2} !== 6'b0) begin bad++; $display("FAIL g3_rst_outputs: got ack %b cmd %b want all 0", ack2, {erase2, dec2, inc2}); end
        total++; if (gid2 !== 2'd0 || busy2 !== 1'b0) begin bad++; $display("FAIL g3_rst_state: got gid %0d busy %b want 0 0", gid2, busy2); end
        foreach (post[k]) exp_q.push_back('{id: post[k], cmd: C_INC});
        for (int k = 0; k < 4; k++) begin
            get_pulse(1'b1, 12, got, cmd, ackv, gid, at);
            e = exp_q.pop_front();
            total++; if (!got || at != rel + 1 + 5 * k) begin bad++; $display("FAIL g3_post_cycle[%0d]: got cycle %0d want %0d", k, at, rel + 1 + 5 * k); end
            total++; if (cmd !== e.cmd || gid !== 2'(e.id) || ackv !== (4'b0001 << e.id)) begin bad++; $display("FAIL g3_post_grant[%0d]: got id %0d cmd %b ack %b want id %0d", k, gid, cmd, ackv, e.id); end
            $display("test_reset_mid_gap3: post grant id=%0d at cycle %0d", gid, at);
        end
        @(posedge clk); #1 req2 = '0;
        repeat (3) @(negedge clk);
        total++; if (busy2 !== 1'b1) begin bad++; $display("FAIL g3_busy_last_gap: got %b want 1", busy2); end
        @(negedge clk);
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL g3_busy_idle: got %b want 0", busy2); end
    endtask

    initial begin
        rst2 = 1'b1; req2 = '0; op2 = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_erase_priority();
        test_null_and_opchange();
        test_reset_mid_gap3();
        total++; if (multi_cnt != 0) begin bad++; $display("FAIL onehot_cmd: got %0d multi-hot cycles want 0", multi_cnt); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/score_arbiter.md
# score_arbiter

Round-robin arbiter that shares one scoreboard command path between N independent requesters, such as referee panels or button stations. Each requester presents a held request with a 2-bit opcode. The arbiter grants one requester at a time and emits a single-cycle inc/dec/erase pulse to the downstream scoreboard controller's inc_i/dec_i/erase_i inputs. It enforces a minimum gap between commands and gives erase requests priority.

## Interface
Parameters:
- N, 4: number of requesters, 2..8.
- GAP, 1: idle cycles after each issued command, minimum 1.
- IW, $clog2(N): width of grant_id.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N  per-requester request level.
- op  in  2N  per-requester opcode; op[2i+1:2i] belongs to requester i. 00 = none, 01 = inc, 10 = dec, 11 = erase.
- ack  out  N  one-cycle pulse to the granted requester.
- inc_o  out  1  one-cycle increment command.
- dec_o  out  1  one-cycle decrement command.
- erase_o  out  1  one-cycle erase command.
- grant_id  out  IW  index of the last granted requester.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, ISSUE, GAP. All outputs are registered.
- A requester is valid when req[i]=1 and its op≠00. When req[i]=1 and op=00, that requester is ignored.
- IDLE:
  - If no requester is valid, stay in IDLE.
  - Otherwise select a winner. If any valid requester has op=11, the candidate set is the erase requesters only; otherwise it is all valid requesters.
  - The winner is the first candidate found searching upward from ptr, wrapping modulo N.
  - Latch the winner's index into grant_id and latch its opcode. Go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Assert exactly one of inc_o/dec_o/erase_o, per the latched opcode.
  - Assert ack[grant_id]. No other ack bit is high.
  - Set ptr <= (grant_id+1) mod N.
  - Load gap_cnt <= GAP-1. Go to GAP.
- GAP:
  - All command outputs and ack are 0.
  - Decrement gap_cnt. When gap_cnt=0, go to IDLE.
- Opcode and req changes after the grant are ignored for the command in flight.
- Requesters must drop req in the cycle after seeing ack. A req still held when the arbiter re-enters IDLE is arbitrated as a new request.
- At most one of inc_o, dec_o, erase_o is high in any cycle. None is high outside ISSUE.
- Reset (rst=1 at a rising edge), from any state including mid-ISSUE or mid-GAP:
  - State becomes IDLE; ptr=0, gap_cnt=0.
  - ack=0, inc_o=dec_o=erase_o=0, grant_id=0, busy=0.
  - The in-flight command is dropped and no ack is issued for it.
  - Requests present during the reset cycle are not granted.
- Sizing: ptr and grant_id are IW bits wide. Wrap-around from N-1 goes to 0, including for non-power-of-two N.

## Timing
- A valid request sampled in IDLE at the edge ending cycle t produces the command pulse and ack in cycle t+1.
- Cycles t+2 .. t+1+GAP are in GAP. The arbiter is back in IDLE in cycle t+2+GAP.
- Back-to-back issued commands are spaced GAP+2 cycles apart (3 cycles at the default GAP=1).
- busy is high from cycle t+1 through t+1+GAP inclusive.
- Arbitration is fair: under continuous non-erase load, each valid requester is granted within N grants.
- Erase requesters can starve inc/dec requesters. This is intended; erase is rare and resets the score.

## Test plan
- Reset: hold rst 2 cycles with all req=1 and op=01 → ack=0, all command outputs 0, busy=0, grant_id=0; the first grant occurs in the second cycle after rst falls, and goes to requester 0.
- Single request: req[1]=1, op1=01 in cycle t → inc_o=1 and ack=0010 in cycle t+1 only, grant_id=1; busy high for cycles t+1..t+2; requester drops req; no further pulses.
- Round-robin: requesters 0, 2, 3 held valid with op=10 from reset release → dec_o pulses 3 cycles apart, grant order 0, 2, 3, 0, 2.
- Erase priority: req0 op=01, req1 op=11, req3 op=01 simultaneously → first pulse is erase_o with ack[1]; then inc for requester 3 (ptr=2), then inc for requester 0.
- Null opcode and opcode change: req2=1 with op=00 → no grant, busy=0. Change op2 to 10 the cycle after a grant of 01 → the issued pulse is still inc_o.
- Reset mid-operation: assert rst in the cycle the arbiter is in ISSUE → next cycle all outputs 0 and state IDLE; with GAP=3, no pulse for 1 cycle after rst falls; ptr restarts at 0.
